// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data_mem arbiter: state encodings, default widths
// and the burst-length clamp helper.
package data_mem_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_EXT  = 1'b1;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_LEN_W        = 4;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_STARVE_LIMIT = 8;

  // Requested beats-1 limited so a burst never exceeds max_burst beats.
  function automatic int clamp_len(input int len, input int max_burst);
    return (len > max_burst - 1) ? max_burst - 1 : len;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between CPU MEM stage, external burst loader and data_mem.
// The arbiter uses the slave modport; the surrounding system uses master.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [LEN_W-1:0]  ext_len;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rdata, ext_done,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rdata, ext_done,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/data_mem_arbiter_wait_counter.sv
// Starvation timer: counts cycles EXT waits behind a busy CPU and flags
// when the preemption threshold is reached.
module data_mem_arbiter_wait_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  logic [CNT_W-1:0] wait_cnt_reg;

  assign hit = (wait_cnt_reg == CNT_W'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (clr) begin
      wait_cnt_reg <= '0;
    end else if (inc && !hit) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data_mem port between the CPU MEM stage and an
// external burst loader. Optional counters: define MEM_ARB_PERF_EN.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_beat_cnt
`endif
);
  logic [0:0]        state_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              we_reg;

  logic              in_ext;
  logic              grant;
  logic              last_beat;
  logic              starve_hit;
  logic              we_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign in_ext    = (state_reg == ARB_EXT);
  assign last_beat = in_ext && (beat_cnt_reg == len_reg);
  assign grant     = !in_ext && bus.ext_req && (!bus.cpu_req || starve_hit);

  data_mem_arbiter_wait_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .inc (!in_ext && bus.ext_req && bus.cpu_req),
    .clr (!bus.ext_req || grant || in_ext),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ARB_IDLE;
      beat_cnt_reg <= '0;
      len_reg      <= '0;
      base_reg     <= '0;
      we_reg       <= 1'b0;
    end else if (grant) begin
      state_reg    <= ARB_EXT;
      beat_cnt_reg <= '0;
      len_reg      <= LEN_W'(clamp_len(int'(bus.ext_len), MAX_BURST));
      base_reg     <= bus.ext_addr;
      we_reg       <= bus.ext_we;
    end else if (in_ext) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (last_beat) begin
        state_reg <= ARB_IDLE;
      end
    end
  end

  // CPU owns the port by default; during a burst the address walks and wraps.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    wdata_mux     = bus.cpu_wdata;
    we_mux        = bus.cpu_req & bus.cpu_we;
    bus.cpu_stall = 1'b0;
    if (in_ext) begin
      bus.mem_addr  = base_reg + ADDR_W'(beat_cnt_reg);
      wdata_mux     = bus.ext_wdata;
      we_mux        = we_reg;
      bus.cpu_stall = bus.cpu_req;
    end
  end

  // Gating with rst keeps data_mem from being written while reset is held.
  assign bus.mem_we    = rst & we_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.ext_gnt   = in_ext;
  assign bus.ext_done  = last_beat;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_beat_cnt  <= '0;
    end else begin
      if (bus.cpu_stall && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (in_ext) begin
        perf_beat_cnt <= perf_beat_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a random
// run against a burst-level reference model. Honours MEM_ARB_PERF_EN.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int MB = 16;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus4 ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_stall, perf_beat, perf_stall4, perf_beat4;
`endif

  data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MB), .STARVE_LIMIT(SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall),
    .perf_beat_cnt  (perf_beat)
`endif
  );

  data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(4), .STARVE_LIMIT(SL)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall4),
    .perf_beat_cnt  (perf_beat4)
`endif
  );

  // data_mem stand-in: read data is a fixed function of the address.
  function automatic logic [15:0] rd_pattern(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  assign bus.mem_rdata  = rd_pattern(bus.mem_addr);
  assign bus4.mem_rdata = rd_pattern(bus4.mem_addr);

  // Reference model state: remaining beats of the current burst, next beat index.
  int         m_left, m_idx, m_wait;
  logic [7:0] m_base;
  logic       m_we;

  task automatic model_reset();
    m_left = 0; m_idx = 0; m_wait = 0; m_base = '0; m_we = 1'b0;
  endtask

  task automatic model_step(output logic [59:0] exp);
    logic gnt, done, stall, we;
    logic [7:0] a;
    logic [15:0] wd;
    if (m_left > 0) begin
      gnt = 1'b1; done = (m_left == 1); stall = bus.cpu_req; we = m_we;
      a = m_base + 8'(m_idx); wd = bus.ext_wdata;
      m_idx++; m_left--;
    end else begin
      gnt = 1'b0; done = 1'b0; stall = 1'b0; we = bus.cpu_req & bus.cpu_we;
      a = bus.cpu_addr; wd = bus.cpu_wdata;
      if (bus.ext_req && (!bus.cpu_req || m_wait == SL - 1)) begin
        m_left = (int'(bus.ext_len) + 1 > MB) ? MB : int'(bus.ext_len) + 1;
        m_base = bus.ext_addr; m_we = bus.ext_we; m_idx = 0; m_wait = 0;
      end else if (bus.ext_req) begin
        m_wait++;
      end else begin
        m_wait = 0;
      end
    end
    exp = {gnt, done, stall, we, a, wd, rd_pattern(a), rd_pattern(a)};
  endtask

  task automatic drive_idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_len = '0; bus.ext_wdata = '0;
    bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
    bus4.ext_req = 0; bus4.ext_we = 0; bus4.ext_addr = '0; bus4.ext_len = '0; bus4.ext_wdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h03;
    @(negedge clk); #1;
    checks++;
    if ({bus.ext_gnt, bus.cpu_stall, bus.ext_done, bus.mem_we} !== 4'b0000)
      $display("FAIL reset_outputs: gnt/stall/done/we=%b required 0000",
               {bus.ext_gnt, bus.cpu_stall, bus.ext_done, bus.mem_we});
    else passes++;
    checks++;
    if ({bus4.ext_gnt, bus4.ext_done} !== 2'b00)
      $display("FAIL reset_outputs4: gnt/done=%b required 00", {bus4.ext_gnt, bus4.ext_done});
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    $display("test_reset: done");
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    drive_idle();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'd5; bus.cpu_wdata = 16'hBEEF;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_stall, bus.ext_gnt} !== {1'b1, 8'd5, 16'hBEEF, 1'b0, 1'b0})
      $display("FAIL cpu_write: we=%b addr=%h wdata=%h stall=%b gnt=%b required 1 05 beef 0 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_stall, bus.ext_gnt);
    else passes++;
    $display("test_cpu_write: addr=%h wdata=%h", bus.mem_addr, bus.mem_wdata);
  endtask

  task automatic test_burst_wrap();
    logic [7:0] base;
    logic [7:0] a;
    base = 8'hFE;
    @(negedge clk);
    drive_idle();
    bus.ext_req = 1; bus.ext_len = 4'd3; bus.ext_addr = base;
    #1;
    checks++;
    if (bus.ext_gnt !== 1'b0) $display("FAIL wrap_grant_cycle: gnt=%b required 0", bus.ext_gnt);
    else passes++;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.ext_req = 0;
      #1;
      a = base + 8'(b);
      checks++;
      if ({bus.ext_gnt, bus.mem_addr, bus.ext_done, bus.ext_rdata} !== {1'b1, a, (b == 3), rd_pattern(a)})
        $display("FAIL wrap_beat%0d: gnt=%b addr=%h done=%b rdata=%h required 1 %h %b %h",
                 b, bus.ext_gnt, bus.mem_addr, bus.ext_done, bus.ext_rdata, a, (b == 3), rd_pattern(a));
      else passes++;
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.ext_gnt, bus.ext_done} !== 2'b00)
      $display("FAIL wrap_idle_after: gnt/done=%b required 00", {bus.ext_gnt, bus.ext_done});
    else passes++;
    $display("test_burst_wrap: 4 beats from %h", base);
  endtask

  task automatic test_starvation();
    int first, beats, stalls;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] s0, b0;
`endif
    first = -1; beats = 0; stalls = 0;
    @(negedge clk);
    drive_idle();
    bus.cpu_req = 1; bus.cpu_addr = 8'h40; bus.ext_req = 1; bus.ext_len = 4'd15; bus.ext_addr = 8'h10;
    #1;
`ifdef MEM_ARB_PERF_EN
    s0 = perf_stall; b0 = perf_beat;
`endif
    for (int c = 0; c < 40 && first < 0; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (bus.ext_gnt) first = c;
    end
    checks++;
    if (first !== 8) $display("FAIL starve_grant_delay: first beat at cycle %0d required 8", first);
    else passes++;
    while (bus.ext_gnt && beats < 40) begin
      beats++;
      if (bus.cpu_stall) stalls++;
      @(negedge clk); #1;
    end
    checks++;
    if ({beats, stalls} !== {32'd16, 32'd16})
      $display("FAIL starve_burst: beats=%0d stalls=%0d required 16 16", beats, stalls);
    else passes++;
    checks++;
    if ({bus.ext_gnt, bus.cpu_stall, bus.mem_addr} !== {1'b0, 1'b0, 8'h40})
      $display("FAIL starve_cpu_after: gnt=%b stall=%b addr=%h required 0 0 40",
               bus.ext_gnt, bus.cpu_stall, bus.mem_addr);
    else passes++;
`ifdef MEM_ARB_PERF_EN
    checks++;
    if ({16'(perf_stall - s0), 16'(perf_beat - b0)} !== {16'd16, 16'd16})
      $display("FAIL perf_counters: stall_delta=%0d beat_delta=%0d required 16 16",
               16'(perf_stall - s0), 16'(perf_beat - b0));
    else passes++;
`endif
    drive_idle();
    $display("test_starvation: grant after %0d cycles, %0d stalled beats", first, stalls);
  endtask

  task automatic test_max_burst_clamp();
    int beats, done_beat;
    beats = 0; done_beat = -1;
    @(negedge clk);
    drive_idle();
    bus4.ext_req = 1; bus4.ext_len = 4'd15; bus4.ext_addr = 8'h20;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus4.ext_req = 0;
      #1;
      if (bus4.ext_gnt) begin
        beats++;
        if (bus4.ext_done) done_beat = beats;
      end else if (beats > 0) begin
        break;
      end
    end
    checks++;
    if ({beats, done_beat} !== {32'd4, 32'd4})
      $display("FAIL clamp_burst: beats=%0d done_on=%0d required 4 4", beats, done_beat);
    else passes++;
    $display("test_max_burst_clamp: %0d beats", beats);
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    seen = 0;
    @(negedge clk);
    drive_idle();
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_len = 4'd7; bus.ext_addr = 8'h30; bus.ext_wdata = 16'h1234;
    @(negedge clk);
    bus.ext_req = 0;
    #1;
    checks++;
    if ({bus.ext_gnt, bus.mem_we} !== 2'b11)
      $display("FAIL rst_mid_beat1: gnt/we=%b required 11", {bus.ext_gnt, bus.mem_we});
    else passes++;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ext_gnt, bus.mem_we, bus.ext_done} !== 3'b000)
      $display("FAIL rst_mid_drop: gnt/we/done=%b required 000", {bus.ext_gnt, bus.mem_we, bus.ext_done});
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.cpu_addr = 8'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.ext_gnt || bus.ext_done) seen++;
      @(negedge clk);
    end
    #1;
    checks++;
    if ({seen, bus.mem_addr} !== {32'd0, 8'h77})
      $display("FAIL rst_mid_after: gnt/done cycles=%0d addr=%h required 0 77", seen, bus.mem_addr);
    else passes++;
    $display("test_reset_mid_burst: burst aborted");
  endtask

  task automatic test_random();
    logic [59:0] exp, act;
    int cpu_pct;
    int bursts;
    bursts = 0;
    apply_reset();
    model_reset();
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      cpu_pct = ((c / 150) % 2 == 0) ? 50 : 95;
      bus.cpu_req   = ($urandom_range(0, 99) < cpu_pct);
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 8'($urandom);
      bus.cpu_wdata = 16'($urandom);
      if (!(bus.ext_req && !bus.ext_gnt && $urandom_range(0, 99) < 90))
        bus.ext_req = ($urandom_range(0, 99) < 30);
      bus.ext_we    = 1'($urandom_range(0, 1));
      bus.ext_addr  = 8'($urandom);
      bus.ext_len   = 4'($urandom);
      bus.ext_wdata = 16'($urandom);
      #1;
      model_step(exp);
      act = {bus.ext_gnt, bus.ext_done, bus.cpu_stall, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.cpu_rdata, bus.ext_rdata};
      checks++;
      if (act !== exp)
        $display("FAIL random_cycle%0d: gnt/done/stall/we/addr/wdata/crd/erd=%h required %h", c, act, exp);
      else passes++;
      if (exp[59] && exp[58]) begin
        bursts++;
        $display("random burst %0d ended at cycle %0d addr=%h", bursts, c, exp[55:48]);
      end
    end
    drive_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_burst_wrap();
    test_starvation();
    test_max_burst_clamp();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
